id_ex_control_stage: RTL

- Decode-side producer of the ALUOp/Funct interface consumed by the EX-stage ALU control decoder. Decodes the IF/ID instruction into main control bits, ALUOp[1:0] and Funct[3:0], and registers them into the ID/EX pipeline register.
- Performs load-use hazard detection: stalls IF/ID and inserts a bubble.
- Honours branch flushes.
- Maintains saturating stall and flush event counters.

---
 rtl/id_ex_control_stage.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/id_ex_control_stage.sv
// ID-stage control decode, load-use hazard detection and ID/EX register.
// Feeds ALUOp/Funct to the EX-stage ALU control decoder.
module id_ex_control_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_id_valid,
  input  logic [31:0]      if_id_instr,
  input  logic             flush,
  output logic             stall_o,
  output logic             ex_valid,
  output logic [1:0]       ex_alu_op,
  output logic [3:0]       ex_funct,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_mem_to_reg,
  output logic             ex_alu_src,
  output logic             ex_branch,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic             illegal_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  logic [6:0] opcode;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;
  logic [3:0] funct;
  logic       is_r;
  logic       is_ld;
  logic       is_st;
  logic       is_br;

  assign opcode = if_id_instr[6:0];
  assign rs1    = if_id_instr[19:15];
  assign rs2    = if_id_instr[24:20];
  assign rd     = if_id_instr[11:7];
  assign funct  = {if_id_instr[30], if_id_instr[14:12]};
  assign is_r   = (opcode == OP_R);
  assign is_ld  = (opcode == OP_LD);
  assign is_st  = (opcode == OP_ST);
  assign is_br  = (opcode == OP_BR);

  logic       legal;
  logic       uses_rs2;
  logic       rd_used;
  logic [1:0] d_alu_op;
  logic       d_rw;
  logic       d_mr;
  logic       d_mw;
  logic       d_m2r;
  logic       d_src;
  logic       d_br;

  // Main control decode of the ID instruction.
  always_comb begin
    legal    = 1'b0;
    uses_rs2 = 1'b0;
    rd_used  = 1'b0;
    d_alu_op = 2'b00;
    d_rw     = 1'b0;
    d_mr     = 1'b0;
    d_mw     = 1'b0;
    d_m2r    = 1'b0;
    d_src    = 1'b0;
    d_br     = 1'b0;
    unique case (1'b1)
      is_r: begin
        legal    = 1'b1;
        uses_rs2 = 1'b1;
        rd_used  = 1'b1;
        d_alu_op = 2'b10;
        d_rw     = 1'b1;
      end
      is_ld: begin
        legal   = 1'b1;
        rd_used = 1'b1;
        d_src   = 1'b1;
        d_mr    = 1'b1;
        d_m2r   = 1'b1;
        d_rw    = 1'b1;
      end
      is_st: begin
        legal    = 1'b1;
        uses_rs2 = 1'b1;
        d_src    = 1'b1;
        d_mw     = 1'b1;
      end
      is_br: begin
        legal    = 1'b1;
        uses_rs2 = 1'b1;
        d_alu_op = 2'b01;
        d_br     = 1'b1;
      end
      default: ;
    endcase
  end

  logic rs1_hit;
  logic rs2_hit;
  logic hazard;
  logic load_en;
  logic ill_d;

  assign rs1_hit = (ex_rd == rs1);
  assign rs2_hit = uses_rs2 & (ex_rd == rs2);
  assign hazard  = if_id_valid & ex_valid & ex_mem_read
                 & (ex_rd != 5'd0) & (rs1_hit | rs2_hit);
  assign stall_o = hazard & ~flush;
  // A stalled illegal op is re-presented, so report it only once.
  assign ill_d   = if_id_valid & ~flush & ~stall_o & ~legal;
  assign load_en = if_id_valid & ~flush & ~stall_o & legal;

  // ID/EX pipeline register; anything not loaded becomes a zeroed bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_alu_op     <= 2'b00;
      ex_funct      <= 4'd0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_branch     <= 1'b0;
      ex_rs1        <= 5'd0;
      ex_rs2        <= 5'd0;
      ex_rd         <= 5'd0;
      illegal_o     <= 1'b0;
    end else begin
      illegal_o <= ill_d;
      if (load_en) begin
        ex_valid      <= 1'b1;
        ex_alu_op     <= d_alu_op;
        ex_funct      <= funct;
        ex_reg_write  <= d_rw;
        ex_mem_read   <= d_mr;
        ex_mem_write  <= d_mw;
        ex_mem_to_reg <= d_m2r;
        ex_alu_src    <= d_src;
        ex_branch     <= d_br;
        ex_rs1        <= rs1;
        ex_rs2        <= rs2;
        ex_rd         <= rd_used ? rd : 5'd0;
      end else begin
        ex_valid      <= 1'b0;
        ex_alu_op     <= 2'b00;
        ex_funct      <= 4'd0;
        ex_reg_write  <= 1'b0;
        ex_mem_read   <= 1'b0;
        ex_mem_write  <= 1'b0;
        ex_mem_to_reg <= 1'b0;
        ex_alu_src    <= 1'b0;
        ex_branch     <= 1'b0;
        ex_rs1        <= 5'd0;
        ex_rs2        <= 5'd0;
        ex_rd         <= 5'd0;
      end
    end
  end

  // Saturating stall and flush event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_o && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (flush && if_id_valid && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule
